button_cmd_arbiter: RTL and testbench

BUTTON_CMD_ARBITER -- requirements
Module: button_cmd_arbiter

---
 rtl/button_cmd_arbiter.sv | 127 ++++++++++++
 tb/tb_button_cmd_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_arbiter.sv
// Button command arbiter: turns debounced button levels into press and
// auto-repeat events, queues one request per button, and presents them round-robin.
module button_cmd_arbiter #(
  parameter  int NUM_BTN       = 4,
  parameter  int HOLD_CYCLES   = 16384,
  parameter  int REPEAT_CYCLES = 4096,
  localparam int IDW           = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [IDW-1:0]     cmd_id,
  output logic               cmd_repeat,
  output logic [NUM_BTN-1:0] pending,
  output logic               overrun
);

  localparam int            CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] rep;
  logic [NUM_BTN-1:0] ev;
  logic [NUM_BTN-1:0] kind;
  logic [NUM_BTN-1:0] kind_next;
  logic [NUM_BTN-1:0] keep;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] pending_next;
  logic [NUM_BTN-1:0] ovr_set;
  logic [CW-1:0]      hold_cnt  [NUM_BTN];
  logic [CW-1:0]      hold_next [NUM_BTN];
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     win;
  logic               found;
  logic               loadable;

  // Repeat fires on the edge the hold count would reach HOLD_CYCLES; the
  // counter reloads instead, so the next event is REPEAT_CYCLES later.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    rise = btn & ~btn_q;
    rep  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_next[i] = '0;
      if (btn[i] && !rise[i]) begin
        if (hold_cnt[i] == HOLD_LAST) begin
          rep[i]       = 1'b1;
          hold_next[i] = RELOAD;
        end else if (hold_cnt[i] < HOLD_MAX) begin
          hold_next[i] = hold_cnt[i] + CW'(1);
        end else begin
          hold_next[i] = hold_cnt[i];
        end
      end
    end
  end

  assign loadable = ~cmd_valid | cmd_ready;

  // Round-robin search starts one past the last winner.
  always_comb begin : grant_sel
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!found && pending[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // An event landing on the bit being granted re-arms it rather than overrunning.
  always_comb begin
    clr = '0;
    if (loadable && found) clr[win] = 1'b1;
    ev           = rise | rep;
    keep         = pending & ~clr;
    pending_next = keep | ev;
    ovr_set      = ev & keep;
    for (int i = 0; i < NUM_BTN; i++) begin
      kind_next[i] = kind[i];
      if (ev[i]) kind_next[i] = keep[i] ? (kind[i] & ~rise[i]) : rep[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_q      <= '0;
      pending    <= '0;
      kind       <= '0;
      overrun    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_repeat <= 1'b0;
      ptr        <= IDW'(NUM_BTN - 1);
      // NOTE: the hold counters are plain flops, not a RAM, so every entry is reset.
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      btn_q    <= btn;
      hold_cnt <= hold_next;
      pending  <= pending_next;
      kind     <= kind_next;
      if (|ovr_set) overrun <= 1'b1;
      if (loadable) begin
        if (found) begin
          cmd_valid  <= 1'b1;
          cmd_id     <= win;
          cmd_repeat <= kind[win];
          ptr        <= win;
        end else begin
          cmd_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Self-checking bench for button_cmd_arbiter: directed vector table, corner
// sequences, then random stimulus against a behavioural model.
module tb_button_cmd_arbiter;

  localparam int NB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic          Clk       = 1'b0;
  logic          Reset_n   = 1'b1;
  logic [NB-1:0] btn       = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [1:0]    cmd_id;
  logic          cmd_repeat;
  logic [NB-1:0] pending;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  button_cmd_arbiter #(
    .NUM_BTN       (NB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .btn        (btn),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_id     (cmd_id),
    .cmd_repeat (cmd_repeat),
    .pending    (pending),
    .overrun    (overrun)
  );

  typedef struct {
    logic [NB-1:0] btn;
    logic          ready;
    logic          exp_valid;
    logic [1:0]    exp_id;
    logic          exp_rep;
    logic [NB-1:0] exp_pend;
  } vec_t;

  vec_t vecs [18];

  // Behavioural model: press age in cycles, one request flag per button.
  bit m_prev [NB];
  bit m_pend [NB];
  bit m_kind [NB];
  int m_age  [NB];
  bit m_valid, m_rep, m_ovr;
  int m_id, m_ptr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_kind[i] = 0; m_age[i] = 0;
    end
    m_valid = 0; m_rep = 0; m_ovr = 0; m_id = 0; m_ptr = NB - 1;
  endfunction

  function automatic void model_edge(input logic [NB-1:0] b, input logic r);
    bit ev [NB];
    bit fresh [NB];
    int w;
    for (int i = 0; i < NB; i++) begin
      ev[i] = 0; fresh[i] = 0;
      if (b[i] && !m_prev[i]) begin
        ev[i] = 1; fresh[i] = 1; m_age[i] = 0;
      end else if (b[i]) begin
        m_age[i]++;
        if (m_age[i] >= HOLD && (m_age[i] - HOLD) % REP == 0) ev[i] = 1;
      end else begin
        m_age[i] = 0;
      end
    end
    if (!m_valid || r) begin
      w = -1;
      for (int k = 1; k <= NB; k++) begin
        int j;
        j = (m_ptr + k) % NB;
        if (w < 0 && m_pend[j]) w = j;
      end
      if (w >= 0) begin
        m_valid = 1; m_id = w; m_rep = m_kind[w]; m_pend[w] = 0; m_ptr = w;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (ev[i]) begin
        if (m_pend[i]) begin
          m_ovr = 1;
          if (fresh[i]) m_kind[i] = 0;
        end else begin
          m_pend[i] = 1;
          m_kind[i] = !fresh[i];
        end
      end
      m_prev[i] = b[i];
    end
  endfunction

  task automatic do_reset();
    Reset_n   = 1'b0;
    btn       = '0;
    cmd_ready = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"},   32'(cmd_valid),  32'(0));
    check({tag, " id"},      32'(cmd_id),     32'(0));
    check({tag, " repeat"},  32'(cmd_repeat), 32'(0));
    check({tag, " pending"}, 32'(pending),    32'(0));
    check({tag, " overrun"}, 32'(overrun),    32'(0));
  endtask

  initial begin
    int nrep;
    int n3;
    logic [NB-1:0] pv;

    // Directed vectors from reset: simultaneous press, single press, backpressure + wrap.
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[1]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1011};
    vecs[2]  = '{4'b1011, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1010};
    vecs[3]  = '{4'b1011, 1'b1, 1'b1, 2'd1, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1011, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0001, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0001};
    vecs[7]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100};
    vecs[10] = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000};
    vecs[11] = '{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[12] = '{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[13] = '{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[14] = '{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[15] = '{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0001};
    vecs[16] = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000};
    vecs[17] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};

    // Asynchronous reset takes effect before any clock edge.
    #1 Reset_n = 1'b0;
    #2 check_idle_outputs("async reset");
    repeat (2) tick();
    Reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      btn       = vecs[i].btn;
      cmd_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d valid", i),   32'(cmd_valid),  32'(vecs[i].exp_valid));
      check($sformatf("vec%0d id", i),      32'(cmd_id),     32'(vecs[i].exp_id));
      check($sformatf("vec%0d repeat", i),  32'(cmd_repeat), 32'(vecs[i].exp_rep));
      check($sformatf("vec%0d pending", i), 32'(pending),    32'(vecs[i].exp_pend));
      check($sformatf("vec%0d overrun", i), 32'(overrun),    32'(0));
    end

    // Auto-repeat: fresh command one cycle after the press, repeats at +9, +13, +17.
    do_reset();
    cmd_ready = 1'b1;
    nrep = 0;
    for (int j = 0; j < 24; j++) begin
      btn = (j < 20) ? 4'b0010 : 4'b0000;
      tick();
      check($sformatf("hold%0d valid", j), 32'(cmd_valid),
            32'((j == 1) || (j == 9) || (j == 13) || (j == 17)));
      if ((j == 1) || (j == 9) || (j == 13) || (j == 17)) begin
        check($sformatf("hold%0d id", j),     32'(cmd_id),     32'(1));
        check($sformatf("hold%0d repeat", j), 32'(cmd_repeat), 32'(j != 1));
      end
      if (cmd_valid === 1'b1 && cmd_repeat === 1'b1) nrep++;
    end
    check("repeat count", 32'(nrep), 32'(3));

    // Overrun: button 3 pressed twice while the output is stalled on button 0.
    do_reset();
    btn = 4'b0001; tick();
    btn = 4'b0000; tick();
    check("ovr setup valid", 32'(cmd_valid), 32'(1));
    btn = 4'b1000; tick();
    btn = 4'b0000; tick();
    check("ovr before", 32'(overrun), 32'(0));
    btn = 4'b1000; tick();
    check("ovr set",     32'(overrun),   32'(1));
    check("ovr pending", 32'(pending),   32'(4'b1000));
    check("ovr hold id", 32'(cmd_id),    32'(0));
    btn = 4'b0000;
    cmd_ready = 1'b1;
    n3 = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (cmd_valid === 1'b1 && cmd_id === 2'd3) n3++;
    end
    check("ovr id3 count", 32'(n3),      32'(1));
    check("ovr sticky",    32'(overrun), 32'(1));

    // Async reset mid-handshake with two requests queued.
    do_reset();
    btn = 4'b0001; tick();
    btn = 4'b0000; tick();
    btn = 4'b0110; tick();
    btn = 4'b0000; tick();
    check("mid pending before", 32'(pending),   32'(4'b0110));
    check("mid valid before",   32'(cmd_valid), 32'(1));
    #3 Reset_n = 1'b0;
    #1 check_idle_outputs("mid reset");
    #1 Reset_n = 1'b1;
    cmd_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("post reset%0d valid", j), 32'(cmd_valid), 32'(0));
    end
    btn = 4'b0100; tick(); tick();
    check("post reset press valid", 32'(cmd_valid), 32'(1));
    check("post reset press id",    32'(cmd_id),    32'(2));

    // Button held through reset release is treated as a fresh press.
    Reset_n = 1'b0;
    btn = 4'b0001;
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();
    check("held reset pending", 32'(pending),   32'(4'b0001));
    tick();
    check("held reset valid",   32'(cmd_valid), 32'(1));
    check("held reset id",      32'(cmd_id),    32'(0));

    // Random stimulus against the behavioural model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 600 == 599) do_reset();
      if ($urandom_range(0, 7) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, 3));
      cmd_ready = ($urandom_range(0, 3) != 0);
      model_edge(btn, cmd_ready);
      tick();
      for (int i = 0; i < NB; i++) pv[i] = m_pend[i];
      check($sformatf("rnd%0d valid", cyc), 32'(cmd_valid), 32'(m_valid));
      if (m_valid) begin
        check($sformatf("rnd%0d id", cyc),     32'(cmd_id),     32'(m_id));
        check($sformatf("rnd%0d repeat", cyc), 32'(cmd_repeat), 32'(m_rep));
      end
      check($sformatf("rnd%0d pending", cyc), 32'(pending), 32'(pv));
      check($sformatf("rnd%0d overrun", cyc), 32'(overrun), 32'(m_ovr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
